// File: rtl/drink_dispense_pkg.sv
// Shared types and constants for the drink dispenser controller.
package drink_dispense_pkg;

    localparam int         NUM_DRINKS   = 6;
    localparam logic [3:0] STOCK_MAX    = 4'd15;
    localparam logic [3:0] STOCK_INIT   = 4'd5;
    localparam logic [7:0] DROP_TIMEOUT = 8'd200;

    localparam logic [7:0] PRICE [NUM_DRINKS] = '{8'd50, 8'd75, 8'd100, 8'd125, 8'd65, 8'd85};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DISPENSE,
        CHANGE,
        REFUND,
        JAM
    } state_t;

    typedef logic [NUM_DRINKS-1:0][3:0] stock_t;

    // Out-of-range selections price at zero; CHECK rejects them separately.
    function automatic logic [7:0] price_of(input logic [2:0] sel);
        logic [7:0] p;
        case (sel)
            3'd0:    p = PRICE[0];
            3'd1:    p = PRICE[1];
            3'd2:    p = PRICE[2];
            3'd3:    p = PRICE[3];
            3'd4:    p = PRICE[4];
            3'd5:    p = PRICE[5];
            default: p = 8'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/drink_dispense_if.sv
// Money-in, chute, restock and change-out signals of the dispenser.
interface drink_dispense_if;
    import drink_dispense_pkg::*;

    logic                  done_money_in;
    logic                  pass;
    logic [7:0]            coin_total;
    logic [2:0]            select_drink;
    logic                  drop_sensor;
    logic                  restock;
    logic [2:0]            restock_drink;
    logic [3:0]            restock_qty;

    logic [NUM_DRINKS-1:0] motor;
    logic                  vend;
    logic [7:0]            change_back;
    logic                  change_valid;
    logic [NUM_DRINKS-1:0] sold_out;
    logic                  busy;
    logic                  fault;

    modport master (
        output done_money_in, pass, coin_total, select_drink, drop_sensor,
               restock, restock_drink, restock_qty,
        input  motor, vend, change_back, change_valid, sold_out, busy, fault
    );

    modport slave (
        input  done_money_in, pass, coin_total, select_drink, drop_sensor,
               restock, restock_drink, restock_qty,
        output motor, vend, change_back, change_valid, sold_out, busy, fault
    );

endinterface

// File: rtl/stock_bank.sv
// Six 4-bit can counters: restock and vend decrement combine before saturation.
module stock_bank
    import drink_dispense_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dec,
    input  logic [2:0]            dec_idx,
    input  logic                  restock,
    input  logic [2:0]            restock_idx,
    input  logic [3:0]            restock_qty,
    output stock_t                stock,
    output logic [NUM_DRINKS-1:0] sold_out
);

    stock_t     stock_q, stock_d;
    logic [4:0] sum;

    always_comb begin
        stock_d = stock_q;
        sum     = '0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            sum = {1'b0, stock_q[i]};
            if (restock && restock_idx == 3'(i))
                sum = sum + {1'b0, restock_qty};
            if (dec && dec_idx == 3'(i) && sum != 5'd0)
                sum = sum - 5'd1;
            stock_d[i] = (sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : sum[3:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stock_q <= {NUM_DRINKS{STOCK_INIT}};
        else
            stock_q <= stock_d;
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_DRINKS; i++)
            sold_out[i] = (stock_q[i] == 4'd0);
    end

    assign stock = stock_q;

endmodule

// File: rtl/drink_dispense.sv
// Vending sequencer: validates a paid selection, runs the motor, returns change.
//
// state    | meaning
// IDLE     | waiting for an accepted money-in result
// CHECK    | one cycle: selection, stock, funds and fault screening
// DISPENSE | motor on, waiting for the chute sensor or the timeout
// CHANGE   | one cycle: pay out total minus price
// REFUND   | one cycle: pay out the full total
// JAM      | one cycle: flag fault, pay out the full total
module drink_dispense
    import drink_dispense_pkg::*;
(
    input logic             clock,
    input logic             reset,
    drink_dispense_if.slave bus
);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            total_q, total_d;
    logic [2:0]            sel_q, sel_d;
    logic [7:0]            change_q, change_d;
    logic                  vend_q, vend_d;
    logic                  fault_q, fault_d;

    stock_t                stock;
    logic [NUM_DRINKS-1:0] sold_out;
    logic                  dec;
    logic [3:0]            stock_sel;
    logic [7:0]            price_sel;
    logic                  sel_valid;
    logic [NUM_DRINKS-1:0] motor;

    stock_bank u_stock (
        .clock       (clock),
        .reset       (reset),
        .dec         (dec),
        .dec_idx     (sel_q),
        .restock     (bus.restock),
        .restock_idx (bus.restock_drink),
        .restock_qty (bus.restock_qty),
        .stock       (stock),
        .sold_out    (sold_out)
    );

    always_comb begin
        stock_sel = '0;
        for (int i = 0; i < NUM_DRINKS; i++)
            if (sel_q == 3'(i))
                stock_sel = stock[i];
    end

    assign sel_valid = (sel_q < 3'(NUM_DRINKS));
    assign price_sel = price_of(sel_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            total_q  <= '0;
            sel_q    <= '0;
            change_q <= '0;
            vend_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            sel_q    <= sel_d;
            change_q <= change_d;
            vend_q   <= vend_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        sel_d    = sel_q;
        change_d = change_q;
        vend_d   = 1'b0;
        fault_d  = fault_q;
        dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.done_money_in && bus.pass) begin
                    total_d = bus.coin_total;
                    sel_d   = bus.select_drink;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (fault_q || !sel_valid || stock_sel == 4'd0 || total_q < price_sel) begin
                    change_d = total_q;
                    state_d  = REFUND;
                end else begin
                    state_d = DISPENSE;
                end
            end
            DISPENSE: begin
                cnt_d = cnt_q + 8'd1;
                // A drop on the timeout cycle still counts as a sale.
                if (bus.drop_sensor) begin
                    dec      = 1'b1;
                    vend_d   = 1'b1;
                    change_d = (total_q >= price_sel) ? (total_q - price_sel) : 8'd0;
                    state_d  = CHANGE;
                end else if (cnt_d == DROP_TIMEOUT) begin
                    fault_d  = 1'b1;
                    change_d = total_q;
                    state_d  = JAM;
                end
            end
            CHANGE, REFUND, JAM: state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Motor is decoded straight from state so reset stops it without a clock.
    always_comb begin
        motor = '0;
        for (int i = 0; i < NUM_DRINKS; i++)
            motor[i] = (state_q == DISPENSE) && (sel_q == 3'(i));
    end

    assign bus.motor        = motor;
    assign bus.vend         = vend_q;
    assign bus.change_back  = change_q;
    assign bus.change_valid = (state_q == CHANGE) || (state_q == REFUND) || (state_q == JAM);
    assign bus.sold_out     = sold_out;
    assign bus.busy         = (state_q != IDLE);
    assign bus.fault        = fault_q;

endmodule
